// File: rtl/mem_pkg.sv
// Shared memory-side definitions: memop encodings, read-owner encoding, widths.
package mem_pkg;

  localparam int MEM_AW = 32;
  localparam int MEM_DW = 32;
  localparam int CNT_W  = 4;

  localparam logic [2:0] MEMOP_LB  = 3'd0;
  localparam logic [2:0] MEMOP_LH  = 3'd1;
  localparam logic [2:0] MEMOP_LW  = 3'd2;
  localparam logic [2:0] MEMOP_LBU = 3'd3;
  localparam logic [2:0] MEMOP_LHU = 3'd4;
  localparam logic [2:0] MEMOP_SB  = 3'd5;
  localparam logic [2:0] MEMOP_SH  = 3'd6;
  localparam logic [2:0] MEMOP_SW  = 3'd7;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } owner_t;

endpackage

// File: rtl/starve_counter.sv
// Saturating starvation counter for the low-priority port.
module starve_counter
  import mem_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Clear wins over increment; the count sticks at its maximum instead of wrapping.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: fixed priority for port 0, starvation escape for
// port 1, one access per cycle, read data routed back to the issuing port.
module dmem_arbiter
  import mem_pkg::*;
#(
  parameter int AW           = MEM_AW,
  parameter int DW           = MEM_DW,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             p0_req,
  input  logic             p0_we,
  input  logic [AW-1:0]    p0_addr,
  input  logic [DW-1:0]    p0_wdata,
  input  logic [2:0]       p0_op,
  input  logic             p1_req,
  input  logic             p1_we,
  input  logic [AW-1:0]    p1_addr,
  input  logic [DW-1:0]    p1_wdata,
  input  logic [2:0]       p1_op,
  output logic             p0_gnt,
  output logic             p1_gnt,
  output logic             p0_rvalid,
  output logic             p1_rvalid,
  output logic [DW-1:0]    p0_rdata,
  output logic [DW-1:0]    p1_rdata,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_datain,
  output logic [2:0]       mem_op,
  output logic             mem_we,
  output logic             mem_en,
  input  logic [DW-1:0]    mem_dataout,
  output logic [CNT_W-1:0] starve_cnt
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  owner_t rd_owner;
  owner_t rd_owner_next;
  logic   p1_denied;

  // Port 1 counts every cycle it waits; any grant or idle cycle resets the wait.
  assign p1_denied = p1_req & ~p1_gnt;

  starve_counter u_starve_counter (
    .clock (clock),
    .reset (reset),
    .inc   (p1_denied),
    .clr   (~p1_denied),
    .cnt   (starve_cnt)
  );

  // Grant selection; nothing is granted while reset is held so no access leaks out.
  always_comb begin
    p0_gnt = 1'b0;
    p1_gnt = 1'b0;
    if (reset) begin
      if (p1_req && (starve_cnt >= LIMIT)) begin
        p1_gnt = 1'b1;
      end else if (p0_req) begin
        p0_gnt = 1'b1;
      end else if (p1_req) begin
        p1_gnt = 1'b1;
      end
    end
  end

  // Memory request mirrors the winner; idle cycles drive an all-zero request.
  always_comb begin
    mem_en     = p0_gnt | p1_gnt;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_datain = '0;
    mem_op     = '0;
    if (p0_gnt) begin
      mem_we     = p0_we;
      mem_addr   = p0_addr;
      mem_datain = p0_wdata;
      mem_op     = p0_op;
    end else if (p1_gnt) begin
      mem_we     = p1_we;
      mem_addr   = p1_addr;
      mem_datain = p1_wdata;
      mem_op     = p1_op;
    end
  end

  // Remember which port issued this cycle's read so next cycle's data finds it.
  always_comb begin
    rd_owner_next = OWN_NONE;
    if (p0_gnt && !p0_we) begin
      rd_owner_next = OWN_P0;
    end else if (p1_gnt && !p1_we) begin
      rd_owner_next = OWN_P1;
    end
  end

  // Owner register; reset drops any read in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_owner <= OWN_NONE;
    end else begin
      rd_owner <= rd_owner_next;
    end
  end

  // Steer the memory's read data to the owning port only; the other sees zeros.
  always_comb begin
    p0_rvalid = 1'b0;
    p1_rvalid = 1'b0;
    p0_rdata  = '0;
    p1_rdata  = '0;
    if (rd_owner == OWN_P0) begin
      p0_rvalid = 1'b1;
      p0_rdata  = mem_dataout;
    end else if (rd_owner == OWN_P1) begin
      p1_rvalid = 1'b1;
      p1_rdata  = mem_dataout;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a randomized run
// against a cycle-level behavioural model of the arbitration rules.
module tb_dmem_arbiter;
  import mem_pkg::*;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int LIMIT = 4;

  logic          clock;
  logic          reset;
  logic          p0_req, p1_req, p0_we, p1_we;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [DW-1:0] p0_wdata, p1_wdata;
  logic [2:0]    p0_op, p1_op;
  logic          p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_datain;
  logic [2:0]    mem_op;
  logic          mem_we, mem_en;
  logic [DW-1:0] mem_dataout;
  logic [3:0]    starve_cnt;

  int errors = 0;
  int checks = 0;

  dmem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clock(clock), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_op(p0_op),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_op(p1_op),
    .p0_gnt(p0_gnt), .p1_gnt(p1_gnt), .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
    .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
    .mem_addr(mem_addr), .mem_datain(mem_datain), .mem_op(mem_op), .mem_we(mem_we),
    .mem_en(mem_en), .mem_dataout(mem_dataout), .starve_cnt(starve_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory contents as a pure function of address.
  function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return {a[15:0], 16'h0} ^ a ^ 32'h5A5AC3C3;
  endfunction

  // Memory model: read data one cycle after an enabled read, garbage otherwise.
  always @(posedge clock) begin
    if (mem_en && !mem_we) mem_dataout <= data_of(mem_addr);
    else                   mem_dataout <= $urandom;
  end

  task automatic idle_inputs();
    p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0; p0_op = '0;
    p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0; p1_op = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    p0_req = 1; p0_we = 1; p0_addr = 32'h40; p0_wdata = 32'h1; p0_op = MEMOP_SW;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++;
    if (mem_en !== 1'b0 || p0_gnt !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_mem_en: mem_en=%b p0_gnt=%b required 0/0", mem_en, p0_gnt);
    end
    checks++;
    if (p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0 || starve_cnt !== 4'd0) begin
      errors++; $display("[TB] FAIL reset_state: p0_rvalid=%b p1_rvalid=%b starve_cnt=%0d required 0/0/0", p0_rvalid, p1_rvalid, starve_cnt);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (p0_gnt !== 1'b1 || mem_en !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_release_gnt: p0_gnt=%b mem_en=%b required 1/1", p0_gnt, mem_en);
    end
    @(posedge clock); #1 idle_inputs();
    @(negedge clock);
    checks++;
    if (p0_rvalid !== 1'b0 || mem_en !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_after_write: p0_rvalid=%b mem_en=%b required 0/0", p0_rvalid, mem_en);
    end
  endtask

  task automatic test_single_read();
    @(posedge clock); #1;
    idle_inputs();
    p0_req = 1; p0_we = 0; p0_addr = 32'h100; p0_op = MEMOP_LW;
    @(negedge clock);
    checks++;
    if (p0_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100 || mem_op !== MEMOP_LW) begin
      errors++; $display("[TB] FAIL single_read_req: gnt=%b en=%b we=%b addr=%h op=%0d required 1/1/0/00000100/%0d", p0_gnt, mem_en, mem_we, mem_addr, mem_op, MEMOP_LW);
    end
    @(posedge clock); #1 idle_inputs();
    @(negedge clock);
    checks++;
    if (p0_rvalid !== 1'b1 || p0_rdata !== 32'hDEADBEEF || p1_rvalid !== 1'b0 || p1_rdata !== '0) begin
      errors++; $display("[TB] FAIL single_read_resp: p0_rvalid=%b p0_rdata=%h p1_rvalid=%b p1_rdata=%h required 1/deadbeef/0/0", p0_rvalid, p0_rdata, p1_rvalid, p1_rdata);
    end
  endtask

  task automatic test_contention();
    logic exp_p1;
    logic [3:0] exp_cnt;
    for (int k = 0; k < LIMIT + 2; k++) begin
      @(posedge clock); #1;
      p0_req = 1; p0_we = 1; p0_addr = 32'h300 + k; p0_wdata = k; p0_op = MEMOP_SW;
      p1_req = 1; p1_we = 1; p1_addr = 32'h900; p1_wdata = 32'hAA; p1_op = MEMOP_SW;
      @(negedge clock);
      exp_p1  = (k == LIMIT);
      exp_cnt = (k <= LIMIT) ? 4'(k) : 4'd0;
      checks++;
      if (p1_gnt !== exp_p1 || p0_gnt !== !exp_p1 || starve_cnt !== exp_cnt) begin
        errors++; $display("[TB] FAIL contention_cycle%0d: p0_gnt=%b p1_gnt=%b cnt=%0d required %b/%b/%0d", k, p0_gnt, p1_gnt, starve_cnt, !exp_p1, exp_p1, exp_cnt);
      end
    end
    @(posedge clock); #1 idle_inputs();
  endtask

  task automatic test_write_routing();
    @(posedge clock); #1;
    idle_inputs();
    p1_req = 1; p1_we = 1; p1_addr = 32'h2000; p1_wdata = 32'h12345678; p1_op = MEMOP_SW;
    @(negedge clock);
    checks++;
    if (p1_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h2000 || mem_datain !== 32'h12345678 || mem_op !== MEMOP_SW) begin
      errors++; $display("[TB] FAIL write_routing: gnt=%b we=%b addr=%h data=%h op=%0d required 1/1/00002000/12345678/%0d", p1_gnt, mem_we, mem_addr, mem_datain, mem_op, MEMOP_SW);
    end
    @(posedge clock); #1 idle_inputs();
    @(negedge clock);
    checks++;
    if (p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0) begin
      errors++; $display("[TB] FAIL write_no_resp: p0_rvalid=%b p1_rvalid=%b required 0/0", p0_rvalid, p1_rvalid);
    end
  endtask

  task automatic test_interleaved();
    @(posedge clock); #1;
    idle_inputs();
    p0_req = 1; p0_addr = 32'h0000_0A10; p0_op = MEMOP_LW;
    @(posedge clock); #1;
    idle_inputs();
    p1_req = 1; p1_addr = 32'h0000_0B20; p1_op = MEMOP_LHU;
    @(negedge clock);
    checks++;
    if (p0_rvalid !== 1'b1 || p0_rdata !== data_of(32'h0A10) || p1_rvalid !== 1'b0 || p1_gnt !== 1'b1) begin
      errors++; $display("[TB] FAIL interleave_p0: p0_rvalid=%b p0_rdata=%h p1_rvalid=%b p1_gnt=%b required 1/%h/0/1", p0_rvalid, p0_rdata, p1_rvalid, p1_gnt, data_of(32'h0A10));
    end
    @(posedge clock); #1 idle_inputs();
    @(negedge clock);
    checks++;
    if (p1_rvalid !== 1'b1 || p1_rdata !== data_of(32'h0B20) || p0_rvalid !== 1'b0 || p0_rdata !== '0) begin
      errors++; $display("[TB] FAIL interleave_p1: p1_rvalid=%b p1_rdata=%h p0_rvalid=%b p0_rdata=%h required 1/%h/0/0", p1_rvalid, p1_rdata, p0_rvalid, p0_rdata, data_of(32'h0B20));
    end
  endtask

  task automatic test_reset_mid_read();
    @(posedge clock); #1;
    idle_inputs();
    p0_req = 1; p0_addr = 32'h100; p0_op = MEMOP_LW;
    @(negedge clock);
    checks++;
    if (p0_gnt !== 1'b1) begin
      errors++; $display("[TB] FAIL midreset_gnt: p0_gnt=%b required 1", p0_gnt);
    end
    #1 reset = 1'b0;
    idle_inputs();
    @(negedge clock);
    checks++;
    if (p0_rvalid !== 1'b0 || p0_rdata !== '0) begin
      errors++; $display("[TB] FAIL midreset_in_reset: p0_rvalid=%b p0_rdata=%h required 0/0", p0_rvalid, p0_rdata);
    end
    #1 reset = 1'b1;
    @(negedge clock);
    checks++;
    if (p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0) begin
      errors++; $display("[TB] FAIL midreset_after: p0_rvalid=%b p1_rvalid=%b required 0/0", p0_rvalid, p1_rvalid);
    end
  endtask

  task automatic test_random();
    int m_cnt;
    int m_pend;
    logic [DW-1:0] m_pdata;
    logic g0, g1;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic [2:0] e_op;
    logic e_we;
    @(posedge clock); #1 idle_inputs();
    @(posedge clock);
    m_cnt = 0; m_pend = 0; m_pdata = '0;
    g0 = 0; g1 = 0;
    for (int i = 0; i < 400; i++) begin
      #1;
      if (!(p0_req && !g0)) begin
        p0_req = ($urandom_range(0, 3) != 0);
        p0_we = $urandom_range(0, 1);
        p0_addr = $urandom; p0_wdata = $urandom;
        p0_op = p0_we ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      end
      if (!(p1_req && !g1)) begin
        p1_req = ($urandom_range(0, 3) != 0);
        p1_we = $urandom_range(0, 1);
        p1_addr = $urandom; p1_wdata = $urandom;
        p1_op = p1_we ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      end
      g1 = p1_req && (m_cnt >= LIMIT || !p0_req);
      g0 = p0_req && !g1;
      e_we = 0; e_addr = '0; e_wdata = '0; e_op = '0;
      if (g0) begin e_we = p0_we; e_addr = p0_addr; e_wdata = p0_wdata; e_op = p0_op; end
      if (g1) begin e_we = p1_we; e_addr = p1_addr; e_wdata = p1_wdata; e_op = p1_op; end
      @(negedge clock);
      checks++;
      if (p0_gnt !== g0 || p1_gnt !== g1 || starve_cnt !== 4'(m_cnt)) begin
        errors++; $display("[TB] FAIL rand_gnt cycle %0d: p0_gnt=%b p1_gnt=%b cnt=%0d required %b/%b/%0d", i, p0_gnt, p1_gnt, starve_cnt, g0, g1, m_cnt);
      end
      checks++;
      if (mem_en !== (g0 | g1) || mem_we !== e_we || mem_addr !== e_addr || mem_datain !== e_wdata || mem_op !== e_op) begin
        errors++; $display("[TB] FAIL rand_mem cycle %0d: en=%b we=%b addr=%h data=%h op=%0d required %b/%b/%h/%h/%0d", i, mem_en, mem_we, mem_addr, mem_datain, mem_op, g0 | g1, e_we, e_addr, e_wdata, e_op);
      end
      checks++;
      if (p0_rvalid !== (m_pend == 1) || p1_rvalid !== (m_pend == 2) ||
          p0_rdata !== ((m_pend == 1) ? m_pdata : '0) || p1_rdata !== ((m_pend == 2) ? m_pdata : '0)) begin
        errors++; $display("[TB] FAIL rand_resp cycle %0d: p0 %b/%h p1 %b/%h required owner=%0d data=%h", i, p0_rvalid, p0_rdata, p1_rvalid, p1_rdata, m_pend, m_pdata);
      end
      @(posedge clock);
      if (p1_req && !g1) m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
      else               m_cnt = 0;
      if (g0 && !p0_we)      begin m_pend = 1; m_pdata = data_of(p0_addr); end
      else if (g1 && !p1_we) begin m_pend = 2; m_pdata = data_of(p1_addr); end
      else                   begin m_pend = 0; m_pdata = '0; end
    end
    #1 idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    test_reset();
    test_single_read();
    test_contention();
    test_write_routing();
    test_interleaved();
    test_reset_mid_read();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single data-memory port between two requesters: the CPU core (port 0) and a system-side master such as a loader or debug port (port 1). Port 0 has fixed priority. A starvation counter guarantees that port 1 is eventually served. The block issues at most one memory access per cycle and routes each read result back to the port that issued it. It sits between the CPU's `dmem*` signals, the auxiliary master, and `dmem`.

## Interface
Parameters:
- `AW`, 32: address width.
- `DW`, 32: data width.
- `STARVE_LIMIT`, 4: number of consecutive denied cycles on port 1 before it takes priority; legal range 1..15.

Ports:
- `clock  in  1`: single clock; all state changes on the rising edge.
- `reset  in  1`: asynchronous, active-low reset.
- `p0_req, p1_req  in  1`: access request, one per port.
- `p0_we, p1_we  in  1`: 1 = write, 0 = read.
- `p0_addr, p1_addr  in  AW`: byte address.
- `p0_wdata, p1_wdata  in  DW`: write data.
- `p0_op, p1_op  in  3`: memop encoding, same as `dmem`.
- `p0_gnt, p1_gnt  out  1`: access accepted this cycle.
- `p0_rvalid, p1_rvalid  out  1`: read data valid for this port.
- `p0_rdata, p1_rdata  out  DW`: read data.
- `mem_addr  out  AW`, `mem_datain  out  DW`, `mem_op  out  3`, `mem_we  out  1`, `mem_en  out  1`: memory request.
- `mem_dataout  in  DW`: memory read data, valid one cycle after an enabled read.
- `starve_cnt  out  4`: current starvation count, for debug.

## Operation
- Arbitration is combinational within the cycle. The grant goes to:
  - port 1 if `p1_req` and `starve_cnt >= STARVE_LIMIT`;
  - else port 0 if `p0_req`;
  - else port 1 if `p1_req`;
  - else nothing.
- At most one `pX_gnt` is high per cycle; `pX_gnt` is never high without `pX_req`.
- A denied requester holds its `req`, `addr`, `we`, `wdata` and `op` stable until granted. The arbiter does not store requests.
- The memory request mirrors the granted port. `mem_en = p0_gnt | p1_gnt`. With no grant, `mem_en = 0`, `mem_we = 0`, and `mem_addr`, `mem_datain` and `mem_op` are driven to 0.
- Owner register `rd_owner` (2 bits: none, P0, P1) is set on the clock edge after a granted read and cleared after a write or an idle cycle.
- In the cycle after a granted read, the owner's `pX_rvalid = 1` and `pX_rdata = mem_dataout`. The other port sees `rvalid = 0` and `rdata = 0`.
- Starvation counter behaviour:
  - increments, saturating at 15, each cycle in which `p1_req` is high and `p1_gnt` is low;
  - clears to 0 on `p1_gnt` or when `p1_req` is low.
- Writes produce no response; `gnt` alone completes them.

## Timing
- Reset (`reset` low): `rd_owner = none`, `starve_cnt = 0`, all `rvalid = 0`, all `rdata = 0`, `mem_en = 0`, `mem_we = 0`.
- Grant latency: 0 cycles; the grant is in the same cycle as `req` when the port wins.
- Read latency: 1 cycle; `rvalid` appears in cycle N+1 for a grant in cycle N.
- Throughput: one access per cycle. Back-to-back reads from alternating ports return in grant order, one per cycle.
- Both ports requesting with `starve_cnt < STARVE_LIMIT`: port 0 wins. The counter increments, so port 1 wins no later than the `STARVE_LIMIT+1`-th contended cycle.
- Reset asserted mid-read: the pending `rvalid` is suppressed and no response is delivered after reset deasserts.
- A read grant and a pending `rvalid` in the same cycle are legal; the new read's response follows in the next cycle.

## Structure
- Shared package `mem_pkg`:
  - memop encodings (`MEMOP_LB`…`MEMOP_SW`);
  - owner encoding constants (`OWN_NONE`, `OWN_P0`, `OWN_P1`);
  - `DW` and `AW` defaults.
- One natural sub-module: `starve_counter`, a saturating counter with `inc`, `clr` and `cnt` outputs.
- Everything else is a flat combinational mux plus two registers.

## Test plan
- Reset: hold `reset` low while `p0_req = 1`. Required: `mem_en = 0`, `p0_rvalid = 0`, `starve_cnt = 0`. After release, `p0_gnt = 1` in the same cycle.
- Single read: port 0 reads address `0x100`, memory returns `0xDEADBEEF`. Required: `p0_gnt = 1` in cycle N; in N+1, `p0_rvalid = 1`, `p0_rdata = 0xDEADBEEF`, `p1_rvalid = 0`.
- Contention: both ports request continuously with `STARVE_LIMIT = 4`. Required:
  - port 0 granted in cycles 0–3;
  - port 1 granted in cycle 4 with `starve_cnt = 4` at that moment;
  - counter 0 afterwards.
- Write routing: port 1 writes `0x12345678` to `0x2000` with op SW, no contention. Required: `mem_we = 1`, `mem_addr = 0x2000`, `mem_datain = 0x12345678`; no `rvalid` on either port in the next cycle.
- Interleaved reads: port 0 reads at cycle N and port 1 reads at N+1. Required: `p0_rvalid` at N+1 and `p1_rvalid` at N+2, each carrying its own address's data.
- Reset mid-read: a port 0 read is granted in cycle N and `reset` is pulled low before edge N+1. Required: `p0_rvalid` never asserts for that read.
